// File: rtl/clkdiv_ctrl.sv
// Run-time controller for a toggle-type clock divider: start, graceful stop, finite
// bursts and handshaked half-period updates applied only at period boundaries.
// Optional macro CLKDIV_CTRL_PERIOD_CNT_EN adds a 32-bit completed-period counter output.
module clkdiv_ctrl #(
   parameter int unsigned W        = 24,
   parameter int unsigned DEF_HALF = 8333333,
   parameter int unsigned BW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic [BW-1:0] burst_len,
   input  logic          div_valid,
   input  logic [W-1:0]  div_data,
   output logic          div_ready,
   output logic          clk_out,
   output logic          tick,
   output logic          busy,
   output logic          done,
   output logic          div_err
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [31:0]   period_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  half_q, half_d;
   logic [W-1:0]  pend_val_q, pend_val_d;
   logic          pending_q, pending_d;
   logic          clk_out_q, clk_out_d;
   logic          tick_q, tick_d;
   logic          done_q, done_d;
   logic          div_err_q, div_err_d;
   logic [BW-1:0] burst_len_q, burst_len_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;

   logic term, fall, start_acc, xfer, burst_hit;

   assign term      = (cnt_q == half_q - W'(1));
   assign fall      = (state_q != S_IDLE) && term && clk_out_q;
   assign start_acc = (state_q == S_IDLE) && start && !stop;
   assign xfer      = div_valid && !pending_q;
   assign burst_hit = (burst_len_q != '0) && (burst_cnt_q >= burst_len_q);

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      pend_val_d  = pend_val_q;
      pending_d   = pending_q;
      clk_out_d   = clk_out_q;
      tick_d      = 1'b0;
      done_d      = 1'b0;
      div_err_d   = xfer && (div_data == '0);
      burst_len_d = burst_len_q;
      burst_cnt_d = burst_cnt_q;

      if (xfer && (div_data != '0)) begin
         pend_val_d = div_data;
         pending_d  = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (pending_q) begin
               half_d    = pend_val_q;
               pending_d = 1'b0;
            end
            if (start_acc) begin
               state_d     = S_RUN;
               burst_len_d = burst_len;
               burst_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (stop && !clk_out_q) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else if (term) begin
               cnt_d     = '0;
               clk_out_d = !clk_out_q;
               tick_d    = 1'b1;
               if (!clk_out_q) begin
                  if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + 1'b1;
               end else if (stop || burst_hit) begin
                  // Falling edge doubles as the graceful end of a stop or a burst.
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (stop) state_d = S_STOPPING;
            end
         end
         S_STOPPING: begin
            if (term) begin
               cnt_d     = '0;
               clk_out_d = 1'b0;
               tick_d    = 1'b1;
               state_d   = S_IDLE;
               done_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // New half-period only takes effect at a falling edge, so phases are never cut short.
      if (fall && pending_q) begin
         half_d    = pend_val_q;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         half_q      <= W'(DEF_HALF);
         pend_val_q  <= '0;
         pending_q   <= 1'b0;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         done_q      <= 1'b0;
         div_err_q   <= 1'b0;
         burst_len_q <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         pend_val_q  <= pend_val_d;
         pending_q   <= pending_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         done_q      <= done_d;
         div_err_q   <= div_err_d;
         burst_len_q <= burst_len_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign div_ready = !pending_q;
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign div_err   = div_err_q;

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   logic [31:0] period_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt_q <= '0;
      end else if (start_acc) begin
         period_cnt_q <= '0;
      end else if (fall && (period_cnt_q != '1)) begin
         period_cnt_q <= period_cnt_q + 1'b1;
      end
   end

   assign period_cnt = period_cnt_q;
`else
   // Completed-period counter not built; the port list omits period_cnt.
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a phase-countdown reference model.
module tb_clkdiv_ctrl;

   localparam int W        = 8;
   localparam int DEF_HALF = 3;
   localparam int BW       = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [BW-1:0] burst_len = '0;
   logic          div_valid = 1'b0;
   logic [W-1:0]  div_data = '0;
   logic          div_ready, clk_out, tick, busy, done, div_err;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   logic [31:0]   period_cnt;
`endif

   clkdiv_ctrl #(.W(W), .DEF_HALF(DEF_HALF), .BW(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .burst_len (burst_len),
      .div_valid (div_valid),
      .div_data  (div_data),
      .div_ready (div_ready),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .done      (done),
      .div_err   (div_err)
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      ,
      .period_cnt(period_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: tracks cycles left in the current phase and a divisor queue.
   bit m_active, m_stopping, m_level, m_tick, m_done, m_err;
   int m_left, m_half, m_blen, m_rises;
   int m_pend[$];
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
   longint m_period;
`endif

   task automatic model_reset();
      m_active = 0; m_stopping = 0; m_level = 0;
      m_tick = 0; m_done = 0; m_err = 0;
      m_left = 0; m_half = DEF_HALF; m_blen = 0; m_rises = 0;
      m_pend.delete();
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      m_period = 0;
`endif
   endtask

   task automatic model_step();
      bit ready, take;
      ready  = (m_pend.size() == 0);
      take   = div_valid && ready && (div_data != 0);
      m_err  = div_valid && ready && (div_data == 0);
      m_tick = 0;
      m_done = 0;
      if (!m_active) begin
         if (m_pend.size() > 0) m_half = m_pend.pop_front();
         if (start && !stop) begin
            m_active = 1; m_stopping = 0; m_level = 0;
            m_left = m_half; m_blen = int'(burst_len); m_rises = 0;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
            m_period = 0;
`endif
         end
      end else if (!m_stopping && stop && !m_level) begin
         m_active = 0; m_level = 0; m_done = 1;
      end else if (m_left == 1) begin
         m_tick = 1;
         if (!m_level) begin
            m_level = 1;
            if (m_rises < 255) m_rises++;
            m_left = m_half;
         end else begin
            m_level = 0;
            if (m_pend.size() > 0) m_half = m_pend.pop_front();
            m_left = m_half;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
            if (m_period < 64'hFFFF_FFFF) m_period++;
`endif
            if (m_stopping || stop || (m_blen != 0 && m_rises >= m_blen)) begin
               m_active = 0; m_done = 1;
            end
         end
      end else begin
         m_left--;
         if (stop) m_stopping = 1;
      end
      if (take) m_pend.push_back(int'(div_data));
   endtask

   task automatic model_compare();
      bit ready;
      ready = (m_pend.size() == 0);
      check("model", {26'd0, clk_out, tick, busy, done, div_err, div_ready},
            {26'd0, m_level, m_tick, m_active, m_done, m_err, ready});
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("model_period", period_cnt, m_period[31:0]);
`endif
   endtask

   // One clock: DUT and model see the same inputs; pulses drop after the edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      start = 1'b0; stop = 1'b0; div_valid = 1'b0;
      @(negedge clk);
      model_compare();
   endtask

   task automatic wait_level(input logic lvl);
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (clk_out == lvl) found = 1;
         else cycle();
      end
      if (!found) check("wait_level_timeout", 32'd0, 32'd1);
   endtask

   task automatic measure_phase(input logic lvl, input int first, output int len);
      bit ended = 0;
      len = first;
      for (int i = 0; i < 100 && !ended; i++) begin
         cycle();
         if (clk_out == lvl) len++;
         else ended = 1;
      end
      if (!ended) check("phase_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic          start;
      logic          stop;
      logic [BW-1:0] blen;
      logic          exp_clk;
      logic          exp_tick;
      logic          exp_busy;
      logic          exp_done;
   } vec_t;

   vec_t vecs[16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len;

      // Burst of 2 at half=3, then start+stop together and a lone stop in IDLE.
      vecs[0]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", {26'd0, clk_out, tick, busy, done, div_err, div_ready}, 32'b000001);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("reset_period", period_cnt, 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         start = vecs[i].start;
         stop = vecs[i].stop;
         burst_len = vecs[i].blen;
         cycle();
         check($sformatf("vec%0d", i), {28'd0, clk_out, tick, busy, done},
               {28'd0, vecs[i].exp_clk, vecs[i].exp_tick, vecs[i].exp_busy, vecs[i].exp_done});
      end

      // Zero divisor is rejected with an error pulse and leaves half at 3.
      div_valid = 1'b1; div_data = '0;
      cycle();
      check("div_err_pulse", div_err, 1'b1);
      check("div_err_ready", div_ready, 1'b1);
      cycle();
      check("div_err_clear", div_err, 1'b0);

      // Stop one cycle after a rising edge: two more high cycles, then fall with done.
      start = 1'b1; burst_len = '0;
      cycle();
      measure_phase(1'b0, 1, len);
      check("first_low_len", len, 32'd3);
      stop = 1'b1;
      cycle();
      check("stop_hi_1", {busy, clk_out}, 2'b11);
      cycle();
      check("stop_hi_2", {busy, clk_out, done}, 3'b110);
      cycle();
      check("stop_fall", {busy, clk_out, tick, done}, 4'b0011);
      cycle();
      check("stop_done_clear", done, 1'b0);

      // Stop while low: back to IDLE at once, no tick.
      start = 1'b1;
      cycle();
      stop = 1'b1;
      cycle();
      check("stop_low", {busy, clk_out, tick, done}, 4'b0001);

      // Divisor change while high takes effect from the falling edge on.
      start = 1'b1; burst_len = '0;
      cycle();
      wait_level(1'b1);
      div_valid = 1'b1; div_data = 8'd5;
      cycle();
      check("div_ready_low", div_ready, 1'b0);
      measure_phase(1'b1, 2, len);
      check("old_high_len", len, 32'd3);
      check("div_ready_back", div_ready, 1'b1);
      measure_phase(1'b0, 1, len);
      check("new_low_len", len, 32'd5);
      measure_phase(1'b1, 1, len);
      check("new_high_len", len, 32'd5);

      // Reset mid-high with a divisor pending: clock drops at once, defaults return.
      wait_level(1'b1);
      cycle();
      div_valid = 1'b1; div_data = 8'd7;
      cycle();
      rst = 1'b1;
      #1;
      check("rst_clk_low", {clk_out, busy, div_ready}, 3'b001);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("rst_period_zero", period_cnt, 32'd0);
`endif
      start = 1'b1; burst_len = '0;
      cycle();
      measure_phase(1'b0, 1, len);
      check("rst_first_low", len, 32'd3);
      for (int k = 0; k < 4; k++) begin
         measure_phase(1'b1, 1, len);
         check($sformatf("period%0d_high", k), len, 32'd3);
         measure_phase(1'b0, 1, len);
         check($sformatf("period%0d_low", k), len, 32'd3);
      end
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      check("period_cnt_4", period_cnt, 32'd4);
`endif

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         start     = ($urandom_range(15) == 0);
         stop      = ($urandom_range(23) == 0);
         burst_len = BW'($urandom_range(4));
         div_valid = ($urandom_range(7) == 0);
         div_data  = W'($urandom_range(6));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
